// File: rtl/lcd_sw_pkg.sv
// -----------------------------------------------------------------------------
// lcd_sw_pkg
// Shared types and constants for the front-panel LCD/switch SPI sequencer.
//   seq_state_t  : main sequencer states
//   init_phase_t : sub-steps used while playing the init ROM table
//   intr_state_t : switch-interrupt tracking states
//   ENT_*        : entry field positions, as offsets from DATA_W
//                  (entry = {dev, cap, data})
//   HDR_ADDR     : frame RAM address of the header word
//   ENT_BASE     : frame RAM address of the first entry
// -----------------------------------------------------------------------------
package lcd_sw_pkg;

    typedef enum logic [3:0] {
        PWRUP,
        INIT,
        IDLE,
        LEN_RD,
        FETCH,
        SEND,
        WAIT,
        GAP,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        IP_RD,
        IP_SEND,
        IP_WAIT,
        IP_GAP
    } init_phase_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_ARMED,
        I_CLEARED
    } intr_state_t;

    // Entry layout: data in [DATA_W-1:0], cap at DATA_W, dev above it.
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_CAP_OFS  = 0;
    localparam int ENT_DEV_OFS  = 1;

    localparam int HDR_ADDR = 0;
    localparam int ENT_BASE = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_sw_intr.sv
// -----------------------------------------------------------------------------
// lcd_sw_intr
// Switch-interrupt tracker: I_IDLE -> I_ARMED -> I_CLEARED -> I_IDLE.
// Holds the captured switch state for the host.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_sw_intr         : switch interrupt, active-low
//   i_sw_intr_clear   : host clear
//   i_cap_stb         : capture strobe from the sequencer (cap entry done)
//   i_cap_data        : switch bits to capture
//   o_sw_data         : captured switch state, all-ones when not armed
//   o_sw_valid        : armed and at least one capture taken
// -----------------------------------------------------------------------------
module lcd_sw_intr
    import lcd_sw_pkg::*;
#(
    parameter int SW_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_sw_intr,
    input  logic            i_sw_intr_clear,
    input  logic            i_cap_stb,
    input  logic [SW_W-1:0] i_cap_data,
    output logic [SW_W-1:0] o_sw_data,
    output logic            o_sw_valid
);

    intr_state_t state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= I_IDLE;
            o_sw_data  <= '1;
            o_sw_valid <= 1'b0;
        end else begin
            case (state)
                I_IDLE: begin
                    if (!i_sw_intr && !i_sw_intr_clear) begin
                        state <= I_ARMED;
                    end
                end
                I_ARMED: begin
                    // Clear wins over a capture landing in the same cycle.
                    if (i_sw_intr_clear) begin
                        state      <= I_CLEARED;
                        o_sw_data  <= '1;
                        o_sw_valid <= 1'b0;
                    end else if (i_cap_stb) begin
                        o_sw_data  <= i_cap_data;
                        o_sw_valid <= 1'b1;
                    end
                end
                I_CLEARED: begin
                    if (i_sw_intr && !i_sw_intr_clear) begin
                        state <= I_IDLE;
                    end
                end
                default: begin
                    state      <= I_IDLE;
                    o_sw_data  <= '1;
                    o_sw_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_sw_seq.sv
// -----------------------------------------------------------------------------
// lcd_sw_seq
// Front-panel LCD/switch SPI sequencer. After a power-up delay it plays
// INIT_LEN words from the init ROM to device 0, then serves host frames from
// DPBRAM: header (length) at address 0, entries {dev, cap, data} from
// address 1. Each word is handed to the SPI master with a start pulse and
// completes on its done pulse, followed by GAP_CYC idle cycles.
//
// Read latency: RD_LAT counts from the cycle the registered address is first
// driven; the word is latched at the end of the RD_LAT-th cycle.
//
// Optional feature macro: LCD_SW_SEQ_TIMEOUT_EN
//   defined   : done-timeout of TMO_CYC cycles, sets sticky o_err
//   undefined : waits for done forever, o_err tied 0
//
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_start              : host frame request (level)
//   o_busy, o_done       : frame in progress / frame finished
//   o_init_done          : sticky, init table played
//   o_rom_addr/i_rom_data: init ROM port
//   o_dpbram_addr/i_dpbram_data : frame RAM port
//   o_spi_start, o_mosi_data, o_dev_sel, i_miso_data, i_spi_done : SPI master
//   i_sw_intr, i_sw_intr_clear, o_sw_data, o_sw_valid : switch interrupt
//   o_err                : sticky timeout error
// -----------------------------------------------------------------------------
module lcd_sw_seq
    import lcd_sw_pkg::*;
#(
    parameter  int DATA_W    = 24,
    parameter  int ADDR_W    = 8,
    parameter  int N_DEV     = 2,
    parameter  int SW_W      = 8,
    parameter  int INIT_LEN  = 117,
    parameter  int PWRUP_DLY = 67_000_000,
    parameter  int GAP_CYC   = 64,
    parameter  int RD_LAT    = 2,
    parameter  int TMO_CYC   = 8192,
    localparam int DEV_W     = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_init_done,
    output logic [ADDR_W-1:0]       o_rom_addr,
    input  logic [DATA_W-1:0]       i_rom_data,
    output logic [ADDR_W-1:0]       o_dpbram_addr,
    input  logic [DATA_W+DEV_W:0]   i_dpbram_data,
    output logic                    o_spi_start,
    output logic [DATA_W-1:0]       o_mosi_data,
    input  logic [DATA_W-1:0]       i_miso_data,
    input  logic                    i_spi_done,
    output logic [N_DEV-1:0]        o_dev_sel,
    input  logic                    i_sw_intr,
    input  logic                    i_sw_intr_clear,
    output logic [SW_W-1:0]         o_sw_data,
    output logic                    o_sw_valid,
    output logic                    o_err
);

    localparam int CAP_BIT = DATA_W + ENT_CAP_OFS;
    localparam int DEV_LSB = DATA_W + ENT_DEV_OFS;
    localparam int CNT_MAX = max2(max2(PWRUP_DLY, TMO_CYC), max2(GAP_CYC, RD_LAT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int K_W     = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_DLY - 1);
    localparam logic [CNT_W-1:0]  RD_LAST    = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [K_W-1:0]    K_LAST     = K_W'(INIT_LEN - 1);
    // Longest frame: entries occupy addresses 1 .. 2^ADDR_W-2.
    localparam logic [ADDR_W-1:0] LEN_MAX    = {{(ADDR_W-1){1'b1}}, 1'b0};

    seq_state_t         state;
    init_phase_t        init_ph;
    logic [CNT_W-1:0]   cnt;        // shared: pwrup, read latency, gap, timeout
    logic [K_W-1:0]     k;          // init ROM word index
    logic [ADDR_W-1:0]  len;
    logic [ADDR_W-1:0]  idx;
    logic               ent_cap;

    logic [ADDR_W-1:0]  hdr_len;
    logic [DEV_W-1:0]   ent_dev;
    logic [N_DEV-1:0]   ent_sel;
    logic               cap_stb;

    assign hdr_len = i_dpbram_data[ADDR_W-1:0];
    assign ent_dev = i_dpbram_data[DEV_LSB +: DEV_W];
    assign ent_sel = N_DEV'(1) << ent_dev;
    assign cap_stb = (state == WAIT) && i_spi_done && ent_cap;

`ifdef LCD_SW_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    logic err_q;
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    generate
        if (SW_W < DATA_W) begin : g_miso_hi
            logic unused_miso_hi;
            assign unused_miso_hi = ^i_miso_data[DATA_W-1:SW_W];
        end
    endgenerate

    // NOTE: every register here is updated with non-blocking assignments so
    // all state moves together on the edge; blocking here would let later
    // statements see half-updated state and break simulation/synthesis match.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= PWRUP;
            init_ph       <= IP_RD;
            cnt           <= '0;
            k             <= '0;
            len           <= '0;
            idx           <= '0;
            ent_cap       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_init_done   <= 1'b0;
            o_rom_addr    <= '0;
            o_dpbram_addr <= '0;
            o_spi_start   <= 1'b0;
            o_mosi_data   <= '0;
            o_dev_sel     <= '0;
`ifdef LCD_SW_SEQ_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            o_spi_start <= 1'b0;

            case (state)
                PWRUP: begin
                    if (cnt == PWRUP_LAST) begin
                        state      <= INIT;
                        init_ph    <= IP_RD;
                        cnt        <= '0;
                        k          <= '0;
                        o_rom_addr <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                INIT: begin
                    case (init_ph)
                        IP_RD: begin
                            if (cnt == RD_LAST) begin
                                o_mosi_data <= i_rom_data;
                                o_dev_sel   <= N_DEV'(1);
                                o_spi_start <= 1'b1;
                                init_ph     <= IP_SEND;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        IP_SEND: begin
                            init_ph <= IP_WAIT;
                            cnt     <= '0;
                        end
                        IP_WAIT: begin
                            if (i_spi_done) begin
                                o_dev_sel <= '0;
                                init_ph   <= IP_GAP;
                                cnt       <= '0;
                            end
`ifdef LCD_SW_SEQ_TIMEOUT_EN
                            else if (cnt == TMO_LAST) begin
                                // Init keeps going after a lost word.
                                err_q     <= 1'b1;
                                o_dev_sel <= '0;
                                init_ph   <= IP_GAP;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
`endif
                        end
                        IP_GAP: begin
                            if (cnt == GAP_LAST) begin
                                if (k == K_LAST) begin
                                    o_init_done <= 1'b1;
                                    state       <= IDLE;
                                end else begin
                                    k          <= k + 1'b1;
                                    o_rom_addr <= ADDR_W'(k + 1'b1);
                                    init_ph    <= IP_RD;
                                    cnt        <= '0;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: init_ph <= IP_RD;
                    endcase
                end

                IDLE: begin
                    if (i_start) begin
                        state         <= LEN_RD;
                        o_busy        <= 1'b1;
                        o_dpbram_addr <= ADDR_W'(HDR_ADDR);
                        cnt           <= '0;
                    end
                end

                LEN_RD: begin
                    if (cnt == RD_LAST) begin
                        if (hdr_len == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            len           <= (hdr_len > LEN_MAX) ? LEN_MAX : hdr_len;
                            idx           <= '0;
                            o_dpbram_addr <= ADDR_W'(ENT_BASE);
                            state         <= FETCH;
                            cnt           <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FETCH: begin
                    // Latch the entry straight into the SPI-facing registers
                    // so the start pulse and its data appear together in SEND.
                    if (cnt == RD_LAST) begin
                        o_mosi_data <= i_dpbram_data[ENT_DATA_LSB +: DATA_W];
                        o_dev_sel   <= ent_sel;
                        ent_cap     <= i_dpbram_data[CAP_BIT];
                        o_spi_start <= 1'b1;
                        state       <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SEND: begin
                    state <= WAIT;
                    cnt   <= '0;
                end

                WAIT: begin
                    // The switch capture itself happens in lcd_sw_intr.
                    if (i_spi_done) begin
                        o_dev_sel <= '0;
                        state     <= GAP;
                        cnt       <= '0;
                    end
`ifdef LCD_SW_SEQ_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        err_q     <= 1'b1;
                        o_dev_sel <= '0;
                        state     <= DONE;
                        o_done    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end

                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (idx + 1'b1 == len) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            idx           <= idx + 1'b1;
                            o_dpbram_addr <= idx + ADDR_W'(ENT_BASE + 1);
                            state         <= FETCH;
                            cnt           <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (!i_start) begin
                        state  <= IDLE;
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                    end
                end

                default: state <= PWRUP;
            endcase
        end
    end

    lcd_sw_intr #(
        .SW_W(SW_W)
    ) u_intr (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_sw_intr       (i_sw_intr),
        .i_sw_intr_clear (i_sw_intr_clear),
        .i_cap_stb       (cap_stb),
        .i_cap_data      (i_miso_data[SW_W-1:0]),
        .o_sw_data       (o_sw_data),
        .o_sw_valid      (o_sw_valid)
    );

endmodule

// File: tb/tb_lcd_sw_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_sw_seq
// Directed bench for lcd_sw_seq with a small ROM/DPBRAM model (one register
// stage, matching RD_LAT = 2 with the DUT's registered address) and an SPI
// model that answers done SPI_LAT cycles after each start.
// -----------------------------------------------------------------------------
module tb_lcd_sw_seq;

    localparam int DATA_W    = 24;
    localparam int ADDR_W    = 8;
    localparam int N_DEV     = 2;
    localparam int SW_W      = 8;
    localparam int INIT_LEN  = 3;
    localparam int PWRUP_DLY = 10;
    localparam int GAP_CYC   = 8;
    localparam int RD_LAT    = 2;
    localparam int TMO_CYC   = 100;
    localparam int ENT_W     = DATA_W + 2;
    localparam int SPI_LAT   = 20;
    localparam int SPACING   = SPI_LAT + GAP_CYC + RD_LAT + 1;

    localparam logic [DATA_W-1:0] ROM_A = 24'hA1A2A3;
    localparam logic [DATA_W-1:0] ROM_B = 24'hB1B2B3;
    localparam logic [DATA_W-1:0] ROM_C = 24'hC1C2C3;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic                 o_busy, o_done, o_init_done;
    logic [ADDR_W-1:0]    o_rom_addr, o_dpbram_addr;
    logic [DATA_W-1:0]    i_rom_data;
    logic [ENT_W-1:0]     i_dpbram_data;
    logic                 o_spi_start;
    logic [DATA_W-1:0]    o_mosi_data;
    logic [DATA_W-1:0]    i_miso_data = '0;
    logic                 i_spi_done;
    logic [N_DEV-1:0]     o_dev_sel;
    logic                 i_sw_intr = 1'b1;
    logic                 i_sw_intr_clear = 1'b0;
    logic [SW_W-1:0]      o_sw_data;
    logic                 o_sw_valid;
    logic                 o_err;

    always #5 i_clk = ~i_clk;

    lcd_sw_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_DEV(N_DEV), .SW_W(SW_W),
        .INIT_LEN(INIT_LEN), .PWRUP_DLY(PWRUP_DLY), .GAP_CYC(GAP_CYC),
        .RD_LAT(RD_LAT), .TMO_CYC(TMO_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_init_done(o_init_done),
        .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_dpbram_addr(o_dpbram_addr), .i_dpbram_data(i_dpbram_data),
        .o_spi_start(o_spi_start), .o_mosi_data(o_mosi_data),
        .i_miso_data(i_miso_data), .i_spi_done(i_spi_done),
        .o_dev_sel(o_dev_sel), .i_sw_intr(i_sw_intr),
        .i_sw_intr_clear(i_sw_intr_clear), .o_sw_data(o_sw_data),
        .o_sw_valid(o_sw_valid), .o_err(o_err)
    );

    // ---------------- memory and SPI models ----------------
    logic [DATA_W-1:0] rom [256];
    logic [ENT_W-1:0]  ram [256];
    logic [DATA_W-1:0] rom_q = '0;
    logic [ENT_W-1:0]  ram_q = '0;
    int                cd = 0;
    bit                spi_mute = 1'b0;
    int                cyc = 0;

    always @(posedge i_clk) begin
        rom_q <= rom[o_rom_addr];
        ram_q <= ram[o_dpbram_addr];
        cyc   <= cyc + 1;
        if (o_spi_start && !spi_mute) cd <= SPI_LAT;
        else if (cd != 0)             cd <= cd - 1;
    end
    assign i_rom_data    = rom_q;
    assign i_dpbram_data = ram_q;
    assign i_spi_done    = (cd == 1);

    // ---------------- start / init_done monitor ----------------
    logic [DATA_W-1:0] st_mosi [$];
    logic [N_DEV-1:0]  st_dev  [$];
    int                st_cyc  [$];
    int                init_rise_cyc = -1;
    bit                init_prev = 1'b0;

    always @(negedge i_clk) begin
        if (o_spi_start) begin
            st_mosi.push_back(o_mosi_data);
            st_dev.push_back(o_dev_sel);
            st_cyc.push_back(cyc);
        end
        if (o_init_done && !init_prev) init_rise_cyc = cyc;
        init_prev = o_init_done;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic clear_log();
        st_mosi.delete();
        st_dev.delete();
        st_cyc.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !o_done; i++) tick(1);
        check(tag, o_done, 1'b1);
    endtask

    task automatic wait_init(input string tag, input int budget);
        for (int i = 0; i < budget && !o_init_done; i++) tick(1);
        check(tag, o_init_done, 1'b1);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && st_mosi.size() < n; i++) tick(1);
        check(tag, st_mosi.size(), n);
    endtask

    task automatic run_frame(input string tag, input int budget);
        i_start = 1'b1;
        wait_done(tag, budget);
        i_start = 1'b0;
        tick(2);
    endtask

    function automatic logic [ENT_W-1:0] ent(input bit dev, input bit cap, input logic [DATA_W-1:0] d);
        return {dev, cap, d};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int t0;
        int n0;
        int errs;
        logic [DATA_W-1:0] exp_d;
        logic [N_DEV-1:0]  exp_s;

        for (int i = 0; i < 256; i++) begin
            rom[i] = '0;
            ram[i] = '0;
        end
        rom[0] = ROM_A;
        rom[1] = ROM_B;
        rom[2] = ROM_C;

        // ---- reset values ----
        tick(3);
        check("rst busy",      o_busy, 1'b0);
        check("rst done",      o_done, 1'b0);
        check("rst init_done", o_init_done, 1'b0);
        check("rst spi_start", o_spi_start, 1'b0);
        check("rst mosi",      o_mosi_data, 24'h0);
        check("rst dev_sel",   o_dev_sel, 2'b00);
        check("rst addrs",     {o_rom_addr, o_dpbram_addr}, 16'h0);
        check("rst sw_data",   o_sw_data, 8'hFF);
        check("rst sw_valid",  o_sw_valid, 1'b0);
        check("rst err",       o_err, 1'b0);

        // ---- power-up and init table ----
        rel = cyc;
        i_rst = 1'b0;
        wait_init("init done", 500);
        check("init starts", st_mosi.size(), 3);
        check("init mosi0", st_mosi[0], ROM_A);
        check("init mosi1", st_mosi[1], ROM_B);
        check("init mosi2", st_mosi[2], ROM_C);
        for (int i = 0; i < 3; i++) check("init dev_sel", st_dev[i], 2'b01);
        check("init first start", st_cyc[0] - rel, PWRUP_DLY + RD_LAT);
        check("init spacing", st_cyc[1] - st_cyc[0], SPACING);
        check("init_done rise", init_rise_cyc - st_cyc[2], SPI_LAT + 1 + GAP_CYC);

        // ---- two-word frame (junk above the length field) ----
        clear_log();
        ram[0] = {18'h2A5A5, 8'd2};
        ram[1] = ent(1'b1, 1'b0, 24'h123456);
        ram[2] = ent(1'b0, 1'b0, 24'hABCDEF);
        i_start = 1'b1;
        wait_done("frame2 done", 500);
        check("frame2 starts", st_mosi.size(), 2);
        check("frame2 mosi0", st_mosi[0], 24'h123456);
        check("frame2 dev0",  st_dev[0], 2'b10);
        check("frame2 mosi1", st_mosi[1], 24'hABCDEF);
        check("frame2 dev1",  st_dev[1], 2'b01);
        check("frame2 spacing", st_cyc[1] - st_cyc[0], SPACING);
        check("frame2 busy", o_busy, 1'b1);
        tick(5);
        check("frame2 hold done", o_done, 1'b1);
        check("frame2 no extra", st_mosi.size(), 2);
        check("frame2 cs released", o_dev_sel, 2'b00);
        i_start = 1'b0;
        tick(2);
        check("frame2 idle done", o_done, 1'b0);
        check("frame2 idle busy", o_busy, 1'b0);

        // ---- switch interrupt capture / clear / re-arm ----
        i_sw_intr = 1'b0;
        tick(2);
        check("armed sw_data", o_sw_data, 8'hFF);
        check("armed sw_valid", o_sw_valid, 1'b0);
        ram[0] = 26'd1;
        ram[1] = ent(1'b0, 1'b1, 24'h00005A);
        i_miso_data = 24'h00005A;
        run_frame("cap frame", 500);
        check("cap sw_data", o_sw_data, 8'h5A);
        check("cap sw_valid", o_sw_valid, 1'b1);
        i_sw_intr_clear = 1'b1;
        tick(1);
        i_sw_intr_clear = 1'b0;
        check("clr sw_data", o_sw_data, 8'hFF);
        check("clr sw_valid", o_sw_valid, 1'b0);
        i_miso_data = 24'h000033;
        run_frame("cleared frame", 500);
        check("cleared no cap", o_sw_data, 8'hFF);
        i_sw_intr = 1'b1;
        tick(1);
        i_sw_intr = 1'b0;
        tick(1);
        i_miso_data = 24'hFFFF77;
        run_frame("rearm frame", 500);
        check("rearm sw_data", o_sw_data, 8'h77);
        check("rearm sw_valid", o_sw_valid, 1'b1);

        // ---- zero-length header ----
        ram[0] = 26'd0;
        n0 = st_mosi.size();
        t0 = cyc;
        i_start = 1'b1;
        tick(1);
        check("len0 busy", o_busy, 1'b1);
        wait_done("len0 done", 10);
        check("len0 latency", (cyc - t0) <= RD_LAT + 2, 1'b1);
        check("len0 no start", st_mosi.size(), n0);
        i_start = 1'b0;
        tick(2);

        // ---- saturated length 0xFF -> 254 words ----
        clear_log();
        ram[0] = 26'hFF;
        for (int i = 1; i < 256; i++) ram[i] = ent(i[0], 1'b0, 24'hC00000 | 24'(i));
        run_frame("len255 done", 12000);
        check("len255 count", st_mosi.size(), 254);
        errs = 0;
        for (int j = 0; j < st_mosi.size(); j++) begin
            exp_d = 24'hC00000 | 24'(j + 1);
            exp_s = ((j + 1) % 2 == 1) ? 2'b10 : 2'b01;
            if (st_mosi[j] !== exp_d || st_dev[j] !== exp_s) errs++;
        end
        check("len255 content", errs, 0);

        // ---- reset during WAIT of word 3 ----
        clear_log();
        ram[0] = 26'd4;
        for (int i = 1; i <= 4; i++) ram[i] = ent(1'b0, 1'b0, 24'h0D0000 | 24'(i));
        i_start = 1'b1;
        wait_starts("rst3 reach word3", 3, 500);
        tick(5);
        i_rst = 1'b1;
        tick(1);
        i_start = 1'b0;
        check("rst3 busy",      o_busy, 1'b0);
        check("rst3 done",      o_done, 1'b0);
        check("rst3 init_done", o_init_done, 1'b0);
        check("rst3 mosi",      o_mosi_data, 24'h0);
        check("rst3 dev_sel",   o_dev_sel, 2'b00);
        check("rst3 addrs",     {o_rom_addr, o_dpbram_addr}, 16'h0);
        check("rst3 sw",        {o_sw_data, o_sw_valid}, 9'h1FE);
        n0 = st_mosi.size();
        rel = cyc;
        i_rst = 1'b0;
        tick(PWRUP_DLY + RD_LAT - 1);
        check("rst3 quiet pwrup", st_mosi.size(), n0);
        tick(1);
        check("rst3 replay start", st_mosi.size(), n0 + 1);
        check("rst3 replay mosi", st_mosi[n0], ROM_A);
        wait_init("rst3 reinit", 500);

        // ---- silent SPI ----
        clear_log();
        spi_mute = 1'b1;
        ram[0] = 26'd1;
        ram[1] = ent(1'b1, 1'b0, 24'h5EED00);
        i_start = 1'b1;
        wait_starts("silent start", 1, 200);
        tick(TMO_CYC);
        check("silent err early", o_err, 1'b0);
        tick(1);
`ifdef LCD_SW_SEQ_TIMEOUT_EN
        check("tmo err", o_err, 1'b1);
        check("tmo done", o_done, 1'b1);
        i_start = 1'b0;
        tick(2);
        check("tmo idle", o_busy, 1'b0);
        check("tmo err sticky", o_err, 1'b1);
`else
        check("hang err", o_err, 1'b0);
        check("hang busy", o_busy, 1'b1);
        check("hang done", o_done, 1'b0);
        check("hang cs held", o_dev_sel, 2'b10);
        check("hang starts", st_mosi.size(), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
